// File: rtl/apb_pid_pkg.sv
// rtl/apb_pid_pkg.sv - shared register map, bit indices and access-FSM encoding for apb_pid_regs
package apb_pid_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_KP     = 8'h08;
    localparam logic [7:0] REG_KI     = 8'h0C;
    localparam logic [7:0] REG_KD     = 8'h10;
    localparam logic [7:0] REG_SP     = 8'h14;
    localparam logic [7:0] REG_FB     = 8'h18;
    localparam logic [7:0] REG_RESULT = 8'h1C;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_SAT  = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ACCESS = 2'd3;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = strb[b] ? wdata[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_pid_access_fsm.sv
// rtl/apb_pid_access_fsm.sv - PCLKEN-gated APB setup/wait/access sequencing with PREADY and commit strobe
module apb_pid_access_fsm
    import apb_pid_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic PCLKEN,
    input  logic PSEL,
    input  logic PENABLE,
    output logic PREADY,
    output logic in_access,
    output logic commit
);

    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    logic [1:0] state;
    logic [1:0] cur;
    logic [1:0] nxt;
    logic [1:0] wcnt;

    // SETUP coincides with the bus setup phase, so it is decoded from IDLE rather than registered;
    // this also covers back-to-back transfers arriving straight after ACCESS.
    always_comb begin
        cur = state;
        if (state == ST_IDLE && PSEL && !PENABLE) begin
            cur = ST_SETUP;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            ST_SETUP:  nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   nxt = (wcnt == 2'd0) ? ST_ACCESS : ST_WAIT;
            ST_ACCESS: nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
            wcnt  <= 2'd0;
        end else if (PCLKEN) begin
            state <= nxt;
            if (cur == ST_SETUP) begin
                wcnt <= WAIT_LOAD;
            end else if (cur == ST_WAIT && wcnt != 2'd0) begin
                wcnt <= wcnt - 2'd1;
            end
        end
    end

    assign PREADY    = !((cur == ST_SETUP && WAIT_STATES > 0) || cur == ST_WAIT);
    assign in_access = (state == ST_ACCESS) && PSEL;
    assign commit    = (state == ST_ACCESS) && PCLKEN && PSEL && PENABLE;

endmodule

// File: rtl/apb_pid_regs.sv
// rtl/apb_pid_regs.sv - APB register slave and req/ack launcher for the PID core; APB_PID_PROT_CHECK_EN rejects unprivileged writes
module apb_pid_regs
    import apb_pid_pkg::*;
#(
    parameter int ADDRWIDTH   = 14,
    parameter int WAIT_STATES = 1,
    parameter int DATAW       = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 PCLKEN,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 pid_req,
    input  logic                 pid_ack,
    output logic [DATAW-1:0]     pid_kp,
    output logic [DATAW-1:0]     pid_ki,
    output logic [DATAW-1:0]     pid_kd,
    output logic [DATAW-1:0]     pid_sp,
    output logic [DATAW-1:0]     pid_fb,
    input  logic                 pid_done,
    input  logic [31:0]          pid_result,
    input  logic                 pid_sat,
    output logic                 irq
);

    logic             in_access, commit;
    logic [7:0]       offs;
    logic             addr_hi, is_field, err, wr;
    logic             ctrl_wr, stat_wr, start, clr, done_evt;
    logic [DATAW-1:0] kp, ki, kd, sp, fb, fld_sel;
    logic             irq_en, busy, done, sat, done_nxt, sat_nxt;
    logic [31:0]      result, merged, rdata;
    logic             unused_bits;

    apb_pid_access_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .PCLKEN    (PCLKEN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .in_access (in_access),
        .commit    (commit)
    );

    assign offs     = {3'b000, PADDR[4:2], 2'b00};
    assign addr_hi  = |PADDR[ADDRWIDTH-1:5];
    assign is_field = (offs >= REG_KP) && (offs <= REG_FB);

    // Operands feed the core directly, so they are frozen by refusing writes while busy.
    always_comb begin
        err = addr_hi;
        if (PWRITE) begin
            if (offs == REG_STATUS && PSTRB[0] && PWDATA[STAT_BUSY]) err = 1'b1;
            if (offs == REG_RESULT) err = 1'b1;
            if (busy && is_field) err = 1'b1;
            if (busy && offs == REG_CTRL && PSTRB[0] && PWDATA[CTRL_START]) err = 1'b1;
`ifdef APB_PID_PROT_CHECK_EN
            if (!PPROT[0]) err = 1'b1;
`endif
        end
    end

    assign wr       = commit && PWRITE && !err;
    assign ctrl_wr  = wr && (offs == REG_CTRL) && PSTRB[0];
    assign stat_wr  = wr && (offs == REG_STATUS) && PSTRB[0];
    assign start    = ctrl_wr && PWDATA[CTRL_START];
    assign clr      = ctrl_wr && PWDATA[CTRL_CLR];
    assign done_evt = pid_done && busy;

    always_comb begin
        fld_sel = '0;
        case (offs)
            REG_KP:  fld_sel = kp;
            REG_KI:  fld_sel = ki;
            REG_KD:  fld_sel = kd;
            REG_SP:  fld_sel = sp;
            REG_FB:  fld_sel = fb;
            default: fld_sel = '0;
        endcase
    end

    assign merged = byte_merge(32'(fld_sel), PWDATA, PSTRB);

    // A completion in the same cycle as CLR or a W1C always leaves DONE set.
    always_comb begin
        done_nxt = done;
        sat_nxt  = sat;
        if (clr) begin
            done_nxt = 1'b0;
            sat_nxt  = 1'b0;
        end
        if (stat_wr && PWDATA[STAT_DONE]) done_nxt = 1'b0;
        if (stat_wr && PWDATA[STAT_SAT])  sat_nxt  = 1'b0;
        if (done_evt) begin
            done_nxt = 1'b1;
            sat_nxt  = sat_nxt | pid_sat;
        end
    end

    always_comb begin
        rdata = '0;
        if (!addr_hi) begin
            case (offs)
                REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
                REG_STATUS: begin
                    rdata[STAT_BUSY] = busy;
                    rdata[STAT_DONE] = done;
                    rdata[STAT_SAT]  = sat;
                end
                REG_KP:     rdata = 32'($signed(kp));
                REG_KI:     rdata = 32'($signed(ki));
                REG_KD:     rdata = 32'($signed(kd));
                REG_SP:     rdata = 32'($signed(sp));
                REG_FB:     rdata = 32'($signed(fb));
                REG_RESULT: rdata = result;
                default:    rdata = '0;
            endcase
        end
    end

    assign PRDATA  = (in_access && !PWRITE && !err) ? rdata : '0;
    assign PSLVERR = in_access && err;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            irq_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sat     <= 1'b0;
            pid_req <= 1'b0;
            irq     <= 1'b0;
            result  <= '0;
            kp      <= '0;
            ki      <= '0;
            kd      <= '0;
            sp      <= '0;
            fb      <= '0;
        end else begin
            if (ctrl_wr) irq_en <= PWDATA[CTRL_IRQ_EN];
            if (wr && offs == REG_KP) kp <= merged[DATAW-1:0];
            if (wr && offs == REG_KI) ki <= merged[DATAW-1:0];
            if (wr && offs == REG_KD) kd <= merged[DATAW-1:0];
            if (wr && offs == REG_SP) sp <= merged[DATAW-1:0];
            if (wr && offs == REG_FB) fb <= merged[DATAW-1:0];
            if (start) begin
                busy    <= 1'b1;
                pid_req <= 1'b1;
            end else begin
                if (pid_req && pid_ack) pid_req <= 1'b0;
                if (done_evt) busy <= 1'b0;
            end
            if (done_evt) begin
                result <= pid_result;
            end else if (clr) begin
                result <= '0;
            end
            done <= done_nxt;
            sat  <= sat_nxt;
            irq  <= irq_en && done;
        end
    end

    assign pid_kp = kp;
    assign pid_ki = ki;
    assign pid_kd = kd;
    assign pid_sp = sp;
    assign pid_fb = fb;

    assign unused_bits = ^{PADDR[1:0], PPROT, merged[31:DATAW]};

endmodule

// File: tb/tb_apb_pid_regs.sv
// tb/tb_apb_pid_regs.sv - scoreboard bench for apb_pid_regs with randomized APB traffic and a PID core stand-in
module tb_apb_pid_regs;

    localparam int WAIT_STATES = 1;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        PCLKEN;
    logic        PSEL, PENABLE, PWRITE;
    logic [13:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        pid_req, pid_ack, pid_done, pid_sat, irq;
    logic [15:0] pid_kp, pid_ki, pid_kd, pid_sp, pid_fb;
    logic [31:0] pid_result;

    apb_pid_regs #(.ADDRWIDTH(14), .WAIT_STATES(WAIT_STATES), .DATAW(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .pid_req(pid_req), .pid_ack(pid_ack),
        .pid_kp(pid_kp), .pid_ki(pid_ki), .pid_kd(pid_kd), .pid_sp(pid_sp), .pid_fb(pid_fb),
        .pid_done(pid_done), .pid_result(pid_result), .pid_sat(pid_sat), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          mon_waits = 0;
    bit          pclk_div = 0;
    bit          core_auto = 1;
    logic [31:0] core_result = 32'h0000_07D0;
    logic        core_sat = 1'b1;

    // Reference model state: plain register values as the programmer sees them.
    logic [15:0] m_fld[5];
    logic        m_irq_en, m_busy, m_done, m_sat;
    logic [31:0] m_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_fld[i] = 16'h0;
        m_irq_en = 0; m_busy = 0; m_done = 0; m_sat = 0; m_result = 32'h0;
    endtask

    task automatic model_access(input logic wr, input logic [13:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [2:0] prot,
                                output logic [31:0] rd, output logic err);
        int w;
        w   = int'(addr) / 4;
        err = (w >= 8);
        rd  = 32'h0;
        if (wr && !err) begin
            if (w == 0 && strb[0] && data[0] && m_busy) err = 1;
            if (w == 1 && strb[0] && data[0]) err = 1;
            if (w >= 2 && w <= 6 && m_busy) err = 1;
            if (w == 7) err = 1;
        end
`ifdef APB_PID_PROT_CHECK_EN
        if (wr && !prot[0]) err = 1;
`endif
        if (!err && !wr) begin
            case (w)
                0: rd = m_irq_en ? 32'h2 : 32'h0;
                1: rd = {29'h0, m_sat, m_done, m_busy};
                2, 3, 4, 5, 6: rd = {{16{m_fld[w-2][15]}}, m_fld[w-2]};
                7: rd = m_result;
                default: rd = 32'h0;
            endcase
        end else if (!err && wr) begin
            if (w == 0 && strb[0]) begin
                m_irq_en = data[1];
                if (data[2]) begin m_result = 0; m_done = 0; m_sat = 0; end
                if (data[0]) m_busy = 1;
            end else if (w == 1 && strb[0]) begin
                if (data[1]) m_done = 0;
                if (data[2]) m_sat = 0;
            end else if (w >= 2 && w <= 6) begin
                for (int b = 0; b < 2; b++) if (strb[b]) m_fld[w-2][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic apb(input logic wr, input logic [13:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot);
        exp_t e;
        int   n;
        bit   go;
        model_access(wr, addr, data, strb, prot, e.rdata, e.err);
        e.waits = WAIT_STATES;
        sbq.push_back(e);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb; PPROT = prot;
        n = 0;
        do begin @(negedge HCLK); go = PCLKEN; @(posedge HCLK); n++; end while (!go && n < 50);
        #1 PENABLE = 1;
        n = 0;
        do begin @(negedge HCLK); go = PCLKEN && PREADY; @(posedge HCLK); n++; end while (!go && n < 50);
        if (!go) chk("apb_timeout", 32'(go), 32'h1);
        #1 PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        int pc_cnt = 0;
        PCLKEN = 1;
        forever begin
            @(posedge HCLK);
            #1;
            pc_cnt++;
            PCLKEN = pclk_div ? (pc_cnt % 3 == 0) : 1'b1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESET && PSEL && PENABLE && PCLKEN) begin
                if (!PREADY) begin
                    mon_waits++;
                end else begin
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 32'h1, 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk("pslverr", 32'(PSLVERR), 32'(e.err));
                        chk("prdata", PRDATA, e.rdata);
                        chk("wait_states", 32'(mon_waits), 32'(e.waits));
                    end
                    mon_waits = 0;
                end
            end
        end
    end

    // Stand-in PID core: ack two cycles after a request, complete a while later.
    initial begin
        bit ok, second;
        pid_ack = 0; pid_done = 0; pid_result = 0; pid_sat = 0;
        forever begin
            @(negedge HCLK);
            if (core_auto && pid_req && !HRESET) begin
                ok = (pid_kp == m_fld[0]) && (pid_ki == m_fld[1]) && (pid_kd == m_fld[2]) &&
                     (pid_sp == m_fld[3]) && (pid_fb == m_fld[4]);
                chk("operands", 32'(ok), 32'h1);
                repeat (2) @(posedge HCLK);
                #1 chk("req_held", 32'(pid_req), 32'h1);
                pid_ack = 1;
                @(posedge HCLK);
                #1 pid_ack = 0;
                @(negedge HCLK);
                chk("req_drop", 32'(pid_req), 32'h0);
                second = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge HCLK);
                    if (pid_req) second = 1;
                end
                chk("no_second_req", 32'(second), 32'h0);
                @(posedge HCLK);
                #1 pid_done = 1; pid_result = core_result; pid_sat = core_sat;
                @(posedge HCLK);
                m_result = core_result; m_done = 1; m_sat = m_sat | core_sat; m_busy = 0;
                #1 pid_done = 0;
                @(negedge HCLK);
                chk("irq_latency", 32'(irq), 32'h0);
                @(negedge HCLK);
                chk("irq_after_done", 32'(irq), 32'(m_irq_en));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 300) begin @(negedge HCLK); n++; end
        chk("compute_done", 32'(m_busy), 32'h0);
        repeat (4) @(posedge HCLK);
        #1;
    endtask

    initial begin
        int          sel;
        logic [13:0] a;
        HRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
        model_reset();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_pready", 32'(PREADY), 32'h1);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pid_req", 32'(pid_req), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(posedge HCLK);
        #1 HRESET = 0;

        for (int i = 0; i < 8; i++) apb(0, 14'(i * 4), 32'h0, 4'h0, 3'b001);

        apb(1, 14'h08, 32'h0000_1234, 4'hF, 3'b001);
        apb(0, 14'h08, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h10, 32'h0000_8001, 4'hF, 3'b001);
        apb(0, 14'h10, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h14, 32'h0000_AB00, 4'b0010, 3'b001);
        apb(0, 14'h14, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h18, 32'hFFFF_FFFF, 4'h0, 3'b001);
        apb(0, 14'h18, 32'h0, 4'h0, 3'b001);

        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(1, 8));
            if (sel == 8) a = 14'($urandom_range(8, 4095) * 4);
            else a = 14'(sel * 4);
            a = a | 14'($urandom_range(0, 3));
            apb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                {2'($urandom_range(0, 3)), 1'b1});
        end
        for (int i = 2; i < 8; i++) apb(0, 14'(i * 4), 32'h0, 4'h0, 3'b001);

        apb(1, 14'h00, 32'h2, 4'h1, 3'b001);
        apb(1, 14'h00, 32'h3, 4'h1, 3'b001);
        apb(1, 14'h0C, 32'h0000_5A5A, 4'hF, 3'b001);
        apb(1, 14'h00, 32'h3, 4'h1, 3'b001);
        apb(0, 14'h04, 32'h0, 4'h0, 3'b001);
        apb(0, 14'h0C, 32'h0, 4'h0, 3'b001);
        wait_idle();
        apb(0, 14'h04, 32'h0, 4'h0, 3'b001);
        apb(0, 14'h1C, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h04, 32'h2, 4'h1, 3'b001);
        apb(0, 14'h04, 32'h0, 4'h0, 3'b001);
        repeat (2) @(negedge HCLK);
        chk("irq_cleared", 32'(irq), 32'h0);
        @(posedge HCLK);
        #1 apb(1, 14'h00, 32'h4, 4'h1, 3'b001);
        apb(0, 14'h04, 32'h0, 4'h0, 3'b001);
        apb(0, 14'h1C, 32'h0, 4'h0, 3'b001);

        core_result = $urandom; core_sat = 0;
        apb(1, 14'h00, 32'h1, 4'h1, 3'b001);
        wait_idle();
        apb(0, 14'h04, 32'h0, 4'h0, 3'b001);
        apb(0, 14'h1C, 32'h0, 4'h0, 3'b001);

        pclk_div = 1;
        apb(0, 14'h08, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h18, 32'h0000_7F3C, 4'hF, 3'b001);
        apb(0, 14'h18, 32'h0, 4'h0, 3'b001);
        apb(0, 14'h24, 32'h0, 4'h0, 3'b001);
        apb(1, 14'h24, 32'h1234_5678, 4'hF, 3'b001);
        pclk_div = 0;
        repeat (4) @(posedge HCLK);
        #1 apb(1, 14'h08, 32'h0000_5555, 4'hF, 3'b000);
        apb(0, 14'h08, 32'h0, 4'h0, 3'b001);

        core_auto = 0;
        apb(1, 14'h00, 32'h1, 4'h1, 3'b001);
        @(negedge HCLK);
        chk("req_before_reset", 32'(pid_req), 32'h1);
        @(posedge HCLK);
        #1 PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 14'h08; PWDATA = 32'h0000_0BAD; PSTRB = 4'hF;
        @(posedge HCLK);
        #1 PENABLE = 1;
        @(negedge HCLK);
        chk("mid_wait_pready", 32'(PREADY), 32'h0);
        HRESET = 1;
        #1;
        chk("reset_pready", 32'(PREADY), 32'h1);
        chk("reset_pid_req", 32'(pid_req), 32'h0);
        PSEL = 0; PENABLE = 0;
        model_reset();
        @(posedge HCLK);
        mon_waits = 0;
        #1 HRESET = 0;
        core_auto = 1;
        for (int i = 0; i < 8; i++) apb(0, 14'(i * 4), 32'h0, 4'h0, 3'b001);

        repeat (5) @(negedge HCLK);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
